// File: rtl/apb_melody_seq.sv
// APB note sequencer: software queues {tone, duration} entries, which are played back
// in order on tone_sel, timed by the shared 1 ms tick, with an optional silent gap between notes.
module apb_melody_seq #(
    parameter int DEPTH  = 8,
    parameter int GAP_MS = 20
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        tick,
    output logic [3:0]  tone_sel,
    output logic        irq
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [3:0]  SILENT    = 4'hF;
    localparam logic [11:0] GAP_TICKS = 12'(GAP_MS);
    localparam logic [1:0]  REG_CTRL  = 2'd0;
    localparam logic [1:0]  REG_STAT  = 2'd1;
    localparam logic [1:0]  REG_NOTE  = 2'd2;
    localparam logic [1:0]  REG_CUR   = 2'd3;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t          state_q, state_d;
    logic [11:0]     cnt_q, cnt_d;
    logic [3:0]      tone_q, tone_d;
    logic            pready_q;
    logic            en_q, ie_q, done_q, done_d, ovf_q, ovf_d;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            pop, set_done;
    logic            xfer, wr_ctrl, wr_stat, wr_note, flush, en_now, full, empty, push;
    logic [3:0]      head_tone, head_play_tone;
    logic [11:0]     head_dur;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign xfer    = PSEL & PENABLE & pready_q;
    assign wr_ctrl = xfer & PWRITE & (PADDR[3:2] == REG_CTRL);
    assign wr_stat = xfer & PWRITE & (PADDR[3:2] == REG_STAT);
    assign wr_note = xfer & PWRITE & (PADDR[3:2] == REG_NOTE);
    assign flush   = wr_ctrl & PWDATA[1];
    // A write clearing EN stops playback on the same edge it lands.
    assign en_now  = wr_ctrl ? PWDATA[0] : en_q;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_note & ~full & ~flush;
    assign count_d = count_q + CW'(push) - CW'(pop);

    assign head_tone      = mem_q[rd_ptr_q][3:0];
    assign head_dur       = mem_q[rd_ptr_q][15:4];
    assign head_play_tone = (head_dur == 12'd0) ? SILENT : head_tone;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        tone_d   = tone_q;
        pop      = 1'b0;
        set_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_q && !empty) begin
                    pop = 1'b1; state_d = PLAY; cnt_d = head_dur; tone_d = head_play_tone;
                end
            end
            PLAY: begin
                if (tick && cnt_q != 12'd0) cnt_d = cnt_q - 12'd1;
                if (cnt_q == 12'd0 || (tick && cnt_q == 12'd1)) begin
                    if (GAP_MS > 0) begin
                        state_d = GAP; cnt_d = GAP_TICKS; tone_d = SILENT;
                    end else if (!empty) begin
                        pop = 1'b1; state_d = PLAY; cnt_d = head_dur; tone_d = head_play_tone;
                    end else begin
                        state_d = IDLE; tone_d = SILENT; set_done = 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    cnt_d = cnt_q - 12'd1;
                    if (cnt_q == 12'd1) begin
                        if (!empty) begin
                            pop = 1'b1; state_d = PLAY; cnt_d = head_dur; tone_d = head_play_tone;
                        end else begin
                            state_d = IDLE; tone_d = SILENT; set_done = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush || !en_now) begin
            state_d  = IDLE;
            cnt_d    = 12'd0;
            tone_d   = SILENT;
            pop      = 1'b0;
            set_done = 1'b0;
        end
    end

    // A W1C landing on the edge that sets a flag leaves the flag set.
    assign done_d = (done_q & ~(wr_stat & PWDATA[8])) | set_done;
    assign ovf_d  = (ovf_q  & ~(wr_stat & PWDATA[9])) | (wr_note & full);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pready_q <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= 12'd0;
            tone_q   <= SILENT;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pready_q <= PSEL & PENABLE & ~pready_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            if (wr_ctrl) begin
                en_q <= PWDATA[0];
                ie_q <= PWDATA[2];
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_d;
            end
        end
    end

    // NOTE: the note storage has no reset; an entry is only read once COUNT says it was written.
    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= PWDATA[15:0];
    end

    always_comb begin
        rdata = '0;
        unique case (PADDR[3:2])
            REG_CTRL: begin
                rdata[0] = en_q;
                rdata[2] = ie_q;
            end
            REG_STAT: begin
                rdata[0]   = (state_q != IDLE);
                rdata[1]   = full;
                rdata[2]   = empty;
                rdata[7:4] = 4'(count_q);
                rdata[8]   = done_q;
                rdata[9]   = ovf_q;
            end
            REG_CUR: begin
                rdata[3:0]  = tone_q;
                rdata[15:4] = cnt_q;
            end
            default: rdata = '0;
        endcase
    end

    assign PRDATA      = (pready_q & PSEL & PENABLE & ~PWRITE) ? rdata : 32'd0;
    assign PREADY      = pready_q;
    assign tone_sel    = tone_q;
    assign irq         = done_q & ie_q;
    assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};

endmodule
